// File: rtl/anti_theft_fsm.sv
// anti_theft_fsm
// Control FSM for the car anti-theft system. Sits directly upstream of the
// countdown timer: it selects the delay interval, issues one-cycle
// start_timer pulses, and consumes the timer's expired level. It also drives
// the siren and the status LED, which blinks from the timer's 1 Hz tick while
// the car is armed.
//
// Every output is a register. The next value of each output is computed
// together with the next state, so the outputs always describe the state
// the FSM has just entered.
//
// expired is ignored while start_timer is high. During that cycle the timer
// is still reloading, and its expired flag may be left over from the
// previous countdown.

module anti_theft_fsm #(
  parameter logic STATUS_BLINK = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_passenger,
  input  logic       reprogram,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic [1:0] interval,
  output logic       start_timer,
  output logic       siren,
  output logic       status
);

  // State encoding. 3'b111 is unused and recovers to ARMED.
  localparam logic [2:0] ST_ARMED           = 3'd0;
  localparam logic [2:0] ST_TRIGGERED       = 3'd1;
  localparam logic [2:0] ST_SOUND_ALARM     = 3'd2;
  localparam logic [2:0] ST_DISARMED_IGN    = 3'd3;
  localparam logic [2:0] ST_WAIT_DOOR_OPEN  = 3'd4;
  localparam logic [2:0] ST_WAIT_DOOR_CLOSE = 3'd5;
  localparam logic [2:0] ST_ARM_DELAY       = 3'd6;

  // Interval codes presented to the timer's time-parameter lookup.
  localparam logic [1:0] IV_ARM_DELAY       = 2'b00;
  localparam logic [1:0] IV_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] IV_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] IV_ALARM_ON        = 2'b11;

  logic [2:0] state_r;
  logic [1:0] interval_r;
  logic       start_timer_r;
  logic       siren_r;
  logic       status_r;

  logic [2:0] state_s;
  logic [1:0] interval_s;
  logic       start_timer_s;
  logic       siren_s;
  logic       status_s;

  logic       expired_valid_s;
  logic       door_any_s;

  // Status LED value while in ARMED.
  // With blinking, the LED starts dark on entry and then toggles on each
  // tick. Without blinking, it is a steady 1.
  function automatic logic armed_status(input logic blink,
                                        input logic entering,
                                        input logic current,
                                        input logic tick);
    logic result;
    if (!blink) begin
      result = 1'b1;
    end else if (entering) begin
      result = 1'b0;
    end else begin
      result = current ^ tick;
    end
    return result;
  endfunction

  // Qualify expired and summarise the doors.
  always_comb begin
    expired_valid_s = expired & ~start_timer_r;
    door_any_s      = door_driver | door_passenger;
  end

  // Next-state and start/interval selection.
  // Priority: reprogram > ignition > door/expired.
  always_comb begin
    state_s       = state_r;
    interval_s    = interval_r;
    start_timer_s = 1'b0;

    if (reprogram) begin
      state_s    = ST_ARMED;
      interval_s = IV_ARM_DELAY;
    end else begin
      case (state_r)
        ST_ARMED: begin
          // Ignition is deliberately ignored here.
          // The driver door wins when both doors open in the same cycle.
          if (door_driver) begin
            state_s       = ST_TRIGGERED;
            interval_s    = IV_DRIVER_DELAY;
            start_timer_s = 1'b1;
          end else if (door_passenger) begin
            state_s       = ST_TRIGGERED;
            interval_s    = IV_PASSENGER_DELAY;
            start_timer_s = 1'b1;
          end else begin
            state_s = ST_ARMED;
          end
        end

        ST_TRIGGERED: begin
          if (ignition) begin
            state_s = ST_DISARMED_IGN;
          end else if (expired_valid_s) begin
            state_s       = ST_SOUND_ALARM;
            interval_s    = IV_ALARM_ON;
            start_timer_s = 1'b1;
          end else begin
            state_s = ST_TRIGGERED;
          end
        end

        ST_SOUND_ALARM: begin
          // Keep sounding in ALARM_ON periods while any door stays open.
          if (ignition) begin
            state_s = ST_DISARMED_IGN;
          end else if (expired_valid_s && !door_any_s) begin
            state_s = ST_ARMED;
          end else if (expired_valid_s) begin
            state_s       = ST_SOUND_ALARM;
            interval_s    = IV_ALARM_ON;
            start_timer_s = 1'b1;
          end else begin
            state_s = ST_SOUND_ALARM;
          end
        end

        ST_DISARMED_IGN: begin
          if (!ignition) begin
            state_s = ST_WAIT_DOOR_OPEN;
          end else begin
            state_s = ST_DISARMED_IGN;
          end
        end

        ST_WAIT_DOOR_OPEN: begin
          // Only the driver leaving the car starts the re-arm sequence.
          if (ignition) begin
            state_s = ST_DISARMED_IGN;
          end else if (door_driver) begin
            state_s = ST_WAIT_DOOR_CLOSE;
          end else begin
            state_s = ST_WAIT_DOOR_OPEN;
          end
        end

        ST_WAIT_DOOR_CLOSE: begin
          if (ignition) begin
            state_s = ST_DISARMED_IGN;
          end else if (!door_driver) begin
            state_s       = ST_ARM_DELAY;
            interval_s    = IV_ARM_DELAY;
            start_timer_s = 1'b1;
          end else begin
            state_s = ST_WAIT_DOOR_CLOSE;
          end
        end

        ST_ARM_DELAY: begin
          // A door reopening abandons the countdown. The start pulse is
          // re-issued only when the driver door closes again.
          if (ignition) begin
            state_s = ST_DISARMED_IGN;
          end else if (door_any_s) begin
            state_s = ST_WAIT_DOOR_CLOSE;
          end else if (expired_valid_s) begin
            state_s = ST_ARMED;
          end else begin
            state_s = ST_ARM_DELAY;
          end
        end

        default: begin
          // Unused encoding: fall back to the safe armed state.
          state_s    = ST_ARMED;
          interval_s = IV_ARM_DELAY;
        end
      endcase
    end
  end

  // Siren and status LED, derived from the state being entered.
  always_comb begin
    siren_s  = 1'b0;
    status_s = 1'b0;

    case (state_s)
      ST_SOUND_ALARM: begin
        siren_s  = 1'b1;
        status_s = 1'b1;
      end

      ST_TRIGGERED: begin
        siren_s  = 1'b0;
        status_s = 1'b1;
      end

      ST_ARMED: begin
        siren_s = 1'b0;
        if (reprogram) begin
          status_s = 1'b0;
        end else begin
          status_s = armed_status(STATUS_BLINK, (state_r != ST_ARMED),
                                  status_r, one_hz_enable);
        end
      end

      default: begin
        siren_s  = 1'b0;
        status_s = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous and also drops any
  // start pulse that is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_ARMED;
      interval_r    <= IV_ARM_DELAY;
      start_timer_r <= 1'b0;
      siren_r       <= 1'b0;
      status_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      interval_r    <= interval_s;
      start_timer_r <= start_timer_s;
      siren_r       <= siren_s;
      status_r      <= status_s;
    end
  end

  // Drive the outputs from their registers.
  always_comb begin
    interval    = interval_r;
    start_timer = start_timer_r;
    siren       = siren_r;
    status      = status_r;
  end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed testbench for anti_theft_fsm.
// The main instance blinks the status LED. A second instance, driven by the
// same inputs, uses a steady status LED.
`timescale 1ns/1ps
module tb_anti_theft_fsm;

  localparam logic [3:0] S_ARMED  = 4'd0;
  localparam logic [3:0] S_TRIG   = 4'd1;
  localparam logic [3:0] S_ALARM  = 4'd2;
  localparam logic [3:0] S_DIS    = 4'd3;
  localparam logic [3:0] S_WOPEN  = 4'd4;
  localparam logic [3:0] S_WCLOSE = 4'd5;
  localparam logic [3:0] S_ADELAY = 4'd6;

  logic       clock;
  logic       reset;
  logic       ignition;
  logic       door_driver;
  logic       door_passenger;
  logic       reprogram;
  logic       expired;
  logic       one_hz_enable;
  logic [1:0] interval;
  logic       start_timer;
  logic       siren;
  logic       status;
  logic [1:0] st_interval;
  logic       st_start_timer;
  logic       st_siren;
  logic       st_status;

  int tests;
  int fails;

  anti_theft_fsm #(.STATUS_BLINK(1'b1)) dut (
    .clock(clock), .reset(reset), .ignition(ignition),
    .door_driver(door_driver), .door_passenger(door_passenger),
    .reprogram(reprogram), .expired(expired), .one_hz_enable(one_hz_enable),
    .interval(interval), .start_timer(start_timer), .siren(siren),
    .status(status)
  );

  anti_theft_fsm #(.STATUS_BLINK(1'b0)) dut_steady (
    .clock(clock), .reset(reset), .ignition(ignition),
    .door_driver(door_driver), .door_passenger(door_passenger),
    .reprogram(reprogram), .expired(expired), .one_hz_enable(one_hz_enable),
    .interval(st_interval), .start_timer(st_start_timer), .siren(st_siren),
    .status(st_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    ignition = 1'b0;
    door_driver = 1'b0;
    door_passenger = 1'b0;
    reprogram = 1'b0;
    expired = 1'b0;
    one_hz_enable = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", {1'b0, dut.state_r}, S_ARMED);
    chk("rst_interval", {2'b00, interval}, 4'd0);
    chk("rst_start", {3'b000, start_timer}, 4'd0);
    chk("rst_siren", {3'b000, siren}, 4'd0);
    chk("rst_status", {3'b000, status}, 4'd0);
    chk("rst_steady_status", {3'b000, st_status}, 4'd0);
    reset = 1'b0;

    step();
    chk("armed_idle_status", {3'b000, status}, 4'd0);
    chk("steady_armed_status", {3'b000, st_status}, 4'd1);

    // Driver trigger: the start pulse lasts one cycle and blanks expired.
    door_driver = 1'b1;
    step();
    door_driver = 1'b0;
    chk("drv_state", {1'b0, dut.state_r}, S_TRIG);
    chk("drv_interval", {2'b00, interval}, 4'd1);
    chk("drv_start", {3'b000, start_timer}, 4'd1);
    chk("drv_status", {3'b000, status}, 4'd1);
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("blank_state", {1'b0, dut.state_r}, S_TRIG);
    chk("blank_start_low", {3'b000, start_timer}, 4'd0);
    step();
    chk("trig_wait", {1'b0, dut.state_r}, S_TRIG);
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("alarm_state", {1'b0, dut.state_r}, S_ALARM);
    chk("alarm_interval", {2'b00, interval}, 4'd3);
    chk("alarm_start", {3'b000, start_timer}, 4'd1);
    chk("alarm_siren", {3'b000, siren}, 4'd1);
    chk("alarm_status", {3'b000, status}, 4'd1);
    step();
    chk("alarm_start_low", {3'b000, start_timer}, 4'd0);

    // Alarm end: restart while a door is open, re-arm once both are closed.
    door_passenger = 1'b1;
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("realarm_state", {1'b0, dut.state_r}, S_ALARM);
    chk("realarm_start", {3'b000, start_timer}, 4'd1);
    chk("realarm_siren", {3'b000, siren}, 4'd1);
    chk("realarm_interval", {2'b00, interval}, 4'd3);
    door_passenger = 1'b0;
    step();
    chk("realarm_start_low", {3'b000, start_timer}, 4'd0);
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("alarm_end_state", {1'b0, dut.state_r}, S_ARMED);
    chk("alarm_end_siren", {3'b000, siren}, 4'd0);
    chk("alarm_end_status", {3'b000, status}, 4'd0);
    chk("alarm_end_start", {3'b000, start_timer}, 4'd0);
    chk("steady_end_status", {3'b000, st_status}, 4'd1);

    // Blink: four ticks give 1,0,1,0, and the LED holds between ticks.
    for (int i = 0; i < 4; i++) begin
      one_hz_enable = 1'b1;
      step();
      one_hz_enable = 1'b0;
      chk("blink_tick", {3'b000, status}, (i % 2 == 0) ? 4'd1 : 4'd0);
      chk("steady_tick", {3'b000, st_status}, 4'd1);
      step();
      chk("blink_hold", {3'b000, status}, (i % 2 == 0) ? 4'd1 : 4'd0);
    end

    // Passenger trigger, then ignition beats a simultaneous expired.
    door_passenger = 1'b1;
    step();
    door_passenger = 1'b0;
    chk("pas_state", {1'b0, dut.state_r}, S_TRIG);
    chk("pas_interval", {2'b00, interval}, 4'd2);
    chk("pas_start", {3'b000, start_timer}, 4'd1);
    step();
    ignition = 1'b1;
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("ign_state", {1'b0, dut.state_r}, S_DIS);
    chk("ign_siren", {3'b000, siren}, 4'd0);
    chk("ign_status", {3'b000, status}, 4'd0);
    chk("ign_start", {3'b000, start_timer}, 4'd0);

    // Re-arm path.
    ignition = 1'b0;
    step();
    chk("wopen_state", {1'b0, dut.state_r}, S_WOPEN);
    door_passenger = 1'b1;
    step();
    door_passenger = 1'b0;
    chk("wopen_pas_ignored", {1'b0, dut.state_r}, S_WOPEN);
    door_driver = 1'b1;
    step();
    chk("wclose_state", {1'b0, dut.state_r}, S_WCLOSE);
    door_driver = 1'b0;
    step();
    chk("adelay_state", {1'b0, dut.state_r}, S_ADELAY);
    chk("adelay_interval", {2'b00, interval}, 4'd0);
    chk("adelay_start", {3'b000, start_timer}, 4'd1);
    step();
    chk("adelay_start_low", {3'b000, start_timer}, 4'd0);
    door_passenger = 1'b1;
    step();
    door_passenger = 1'b0;
    chk("abandon_state", {1'b0, dut.state_r}, S_WCLOSE);
    chk("abandon_no_start", {3'b000, start_timer}, 4'd0);
    step();
    chk("adelay2_state", {1'b0, dut.state_r}, S_ADELAY);
    chk("adelay2_start", {3'b000, start_timer}, 4'd1);
    step();
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("rearmed_state", {1'b0, dut.state_r}, S_ARMED);
    chk("rearmed_status", {3'b000, status}, 4'd0);

    // Both doors open together: the driver door wins.
    door_driver = 1'b1;
    door_passenger = 1'b1;
    step();
    door_driver = 1'b0;
    door_passenger = 1'b0;
    chk("both_interval", {2'b00, interval}, 4'd1);
    chk("both_start", {3'b000, start_timer}, 4'd1);

    // Asynchronous reset in the middle of the start pulse.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", {1'b0, dut.state_r}, S_ARMED);
    chk("arst_start", {3'b000, start_timer}, 4'd0);
    chk("arst_interval", {2'b00, interval}, 4'd0);
    chk("arst_status", {3'b000, status}, 4'd0);
    #1;
    reset = 1'b0;
    step();
    chk("arst_no_pending", {3'b000, start_timer}, 4'd0);
    chk("arst_after_state", {1'b0, dut.state_r}, S_ARMED);

    // Reprogram from SOUND_ALARM.
    door_driver = 1'b1;
    step();
    door_driver = 1'b0;
    step();
    expired = 1'b1;
    step();
    expired = 1'b0;
    chk("rp_pre_state", {1'b0, dut.state_r}, S_ALARM);
    chk("rp_pre_siren", {3'b000, siren}, 4'd1);
    reprogram = 1'b1;
    step();
    chk("rp_state", {1'b0, dut.state_r}, S_ARMED);
    chk("rp_siren", {3'b000, siren}, 4'd0);
    chk("rp_interval", {2'b00, interval}, 4'd0);
    chk("rp_status", {3'b000, status}, 4'd0);
    one_hz_enable = 1'b1;
    door_driver = 1'b1;
    step();
    one_hz_enable = 1'b0;
    chk("rp_hold_state", {1'b0, dut.state_r}, S_ARMED);
    chk("rp_no_blink", {3'b000, status}, 4'd0);
    chk("rp_steady_status", {3'b000, st_status}, 4'd0);
    chk("rp_no_start", {3'b000, start_timer}, 4'd0);
    door_driver = 1'b0;
    reprogram = 1'b0;
    step();
    chk("rp_release_state", {1'b0, dut.state_r}, S_ARMED);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
